apb_completer: RTL and testbench

//  APB completer (responder): answers psel/penable/pwrite/pstrb transfers with pready, prdata, pslverr.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_reg_bank.sv | 51 +++++
 rtl/apb_completer.sv | 171 +++++++++++++++++
 tb/tb_apb_completer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM type and default geometry for the APB completer.
// Optional error responses are enabled by defining APB_SLVERR_EN.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W      = 8;
  localparam int APB_DATA_W      = 32;
  localparam int APB_NREGS       = 8;
  localparam int APB_WAIT_CYCLES = 2;
  localparam int APB_CNT_W       = 4;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: NREGS x DATA_W flops with byte-lane writes,
// async clear and a combinational read mux (0 when out of range).
module apb_reg_bank #(
  parameter int NREGS  = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_W/8-1:0]     wr_strb,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_W-1:0]       rd_data,
  output logic [NREGS*DATA_W-1:0] reg_q
);

  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_idx == IDX_W'(i) && wr_strb[b]) begin
            mem[i][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_data = mem[i];
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign reg_q[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/apb_completer.sv
// apb_completer: APB responder with fixed wait states over a register bank.
// Define APB_SLVERR_EN to flag out-of-range accesses on pslverr.
import apb_pkg::*;

module apb_completer #(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int NREGS       = APB_NREGS,
  parameter int WAIT_CYCLES = APB_WAIT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_W-1:0]       paddr,
  input  logic [DATA_W-1:0]       pwdata,
  input  logic [DATA_W/8-1:0]     pstrb,
  output logic                    pready,
  output logic [DATA_W-1:0]       prdata,
  output logic                    pslverr,
  output logic [NREGS*DATA_W-1:0] reg_q
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int STRB_W = strb_w(DATA_W);
  localparam int CNT_W  = APB_CNT_W;

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
  localparam logic [IDX_W:0] NREGS_L = (IDX_W+1)'(NREGS);

  apb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;

  logic [IDX_W-1:0]  paddr_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_wr;
  logic              setup;
  logic              access;
  logic              to_resp;
  logic              wr_ok;
  logic              commit;
  logic [STRB_W-1:0] wr_strb;
  logic [DATA_W-1:0] rd_data;
  logic              pready_d;
  logic [DATA_W-1:0] prdata_d;
  logic              unused_paddr;

  assign paddr_idx    = paddr[ADDR_W-1:2];
  assign unused_paddr = ^paddr[1:0];
  assign setup        = psel & ~penable;
  assign access       = psel & penable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    to_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          idx_d = paddr_idx;
          wr_d  = pwrite;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            to_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (penable) begin
          if (cnt_q == '0) begin
            state_d = RESP;
            to_resp = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With no wait states the response is built from the live setup address
  assign sel_idx = (state_q == IDLE) ? paddr_idx : idx_q;
  assign sel_wr  = (state_q == IDLE) ? pwrite : wr_q;
  assign wr_ok   = {1'b0, idx_q} < NREGS_L;

  always_comb begin
    pready_d = to_resp;
    prdata_d = '0;
    if (to_resp && !sel_wr) begin
      prdata_d = rd_data;
    end
    commit  = (state_q == RESP) && access && pwrite && wr_ok;
    wr_strb = commit ? pstrb : '0;
  end

`ifdef APB_SLVERR_EN
  logic rd_ok;
  logic pslverr_d;

  assign rd_ok     = {1'b0, sel_idx} < NREGS_L;
  assign pslverr_d = to_resp & ~rd_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pslverr <= 1'b0;
    end else begin
      pslverr <= pslverr_d;
    end
  end
`else
  assign pslverr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pready <= 1'b0;
      prdata <= '0;
    end else begin
      pready <= pready_d;
      prdata <= prdata_d;
    end
  end

  apb_reg_bank #(
    .NREGS (NREGS),
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .wr_idx (idx_q),
    .wr_strb(wr_strb),
    .wr_data(pwdata),
    .rd_idx (sel_idx),
    .rd_data(rd_data),
    .reg_q  (reg_q)
  );

endmodule

// File: tb/tb_apb_completer.sv
// tb_apb_completer: randomized self-checking bench for apb_completer,
// one instance with two wait states and one with none.
module tb_apb_completer;

  localparam int NR = 8;

`ifdef APB_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        tgt = 1'b0;

  logic [1:0]            sel_v;
  logic [1:0]            rdy;
  logic [1:0]            err;
  logic [1:0][31:0]      rdata;
  logic [1:0][NR*32-1:0] regq;

  assign sel_v = {psel & tgt, psel & ~tgt};

  apb_completer #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .psel(sel_v[0]),
    .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(rdy[0]), .prdata(rdata[0]),
    .pslverr(err[0]), .reg_q(regq[0])
  );

  apb_completer #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .psel(sel_v[1]),
    .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .pready(rdy[1]), .prdata(rdata[1]),
    .pslverr(err[1]), .reg_q(regq[1])
  );

  int runs = 0;
  int fails = 0;
  int cyc = 0;
  logic [1:0] prev_rdy = '0;
  logic [1:0] dbl = '0;
  logic [31:0] model [2][NR];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    dbl <= dbl | (rdy & prev_rdy);
    prev_rdy <= rdy;
  end

  function automatic logic [NR*32-1:0] flat(input int t);
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = model[t][i];
    return v;
  endfunction

  function automatic logic [31:0] exp_rd(input int t, input logic [7:0] a);
    int idx;
    idx = int'(a[7:2]);
    return (idx < NR) ? model[t][idx] : 32'h0;
  endfunction

  task automatic model_wr(input int t, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[7:2]);
    if (idx < NR)
      for (int b = 0; b < 4; b++)
        if (s[b]) model[t][idx][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic model_clear();
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < NR; i++) model[t][i] = '0;
  endtask

  // Called right after a falling edge; returns right after the falling
  // edge that follows the completing cycle, with the bus idle.
  task automatic xfer(input int t, input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int at,
                      output logic rdy_aft, output logic [31:0] rd_aft);
    tgt = t[0]; psel = 1'b1; penable = 1'b0;
    pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(negedge clk);
    penable = 1'b1;
    lat = 1;
    while (rdy[t] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata[t]; er = err[t]; at = cyc;
    @(negedge clk);
    rdy_aft = rdy[t]; rd_aft = rdata[t];
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd, rda; logic er, ra; int lat, at;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      runs++;
      if (rdy[t] !== 1'b0 || rdata[t] !== 32'h0 || err[t] !== 1'b0) begin
        fails++;
        $display("FAIL reset_out[%0d] got rdy=%b rd=%h err=%b want 0/0/0",
                 t, rdy[t], rdata[t], err[t]);
      end
      runs++;
      if (regq[t] !== '0) begin
        fails++;
        $display("FAIL reset_regs[%0d] got %h want 0", t, regq[t]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    xfer(0, 1'b1, 8'h0C, 32'hA5A5_1234, 4'hF, rd, er, lat, at, ra, rda);
    xfer(1, 1'b1, 8'h08, 32'h0BAD_F00D, 4'hF, rd, er, lat, at, ra, rda);
    tgt = 1'b0; psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h7777_7777; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    runs++;
    if (rdy[0] !== 1'b0 || rdata[0] !== 32'h0 || err[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_midwait got rdy=%b rd=%h err=%b want 0/0/0",
               rdy[0], rdata[0], err[0]);
    end
    runs++;
    if (regq[0] !== '0 || regq[1] !== '0) begin
      fails++;
      $display("FAIL reset_clear got %h %h want 0", regq[0], regq[1]);
    end
    psel = 1'b0; penable = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    logic [31:0] rd, rda; logic er, ra; int lat, at;
    xfer(0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, rd, er, lat, at, ra, rda);
    model_wr(0, 8'h04, 32'hDEAD_BEEF, 4'hF);
    runs++;
    if (lat != 3 || ra !== 1'b0) begin
      fails++;
      $display("FAIL write_timing got lat=%0d after=%b want 3/0", lat, ra);
    end
    runs++;
    if (regq[0][63:32] !== 32'hDEAD_BEEF || regq[0] !== flat(0)) begin
      fails++;
      $display("FAIL write_reg1 got %h want %h", regq[0], flat(0));
    end
  endtask

  task automatic test_partial();
    logic [31:0] rd, rda; logic er, ra; int lat, at;
    xfer(0, 1'b1, 8'h04, 32'h1122_3344, 4'b0101, rd, er, lat, at, ra, rda);
    model_wr(0, 8'h04, 32'h1122_3344, 4'b0101);
    runs++;
    if (regq[0][63:32] !== model[0][1]) begin
      fails++;
      $display("FAIL partial_reg got %h want %h",
               regq[0][63:32], model[0][1]);
    end
    xfer(0, 1'b0, 8'h05, 32'h0, 4'h0, rd, er, lat, at, ra, rda);
    runs++;
    if (rd !== 32'hDE22_BE44 || rda !== 32'h0 || lat != 3) begin
      fails++;
      $display("FAIL partial_read got rd=%h after=%h lat=%0d want %h/0/3",
               rd, rda, lat, 32'hDE22_BE44);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd, rda; logic er, ra; int lat, at;
    logic [7:0] a [2];
    a[0] = 8'h20; a[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      xfer(0, 1'b1, a[k], $urandom, 4'hF, rd, er, lat, at, ra, rda);
      runs++;
      if (er !== SLV || regq[0] !== flat(0) || lat != 3) begin
        fails++;
        $display("FAIL oor_write got err=%b lat=%0d want err=%b lat=3",
                 er, lat, SLV);
      end
      xfer(0, 1'b0, a[k], 32'h0, 4'hF, rd, er, lat, at, ra, rda);
      runs++;
      if (rd !== 32'h0 || er !== SLV) begin
        fails++;
        $display("FAIL oor_read got rd=%h err=%b want 0/%b", rd, er, SLV);
      end
    end
  endtask

  task automatic test_abort();
    int hi;
    hi = 0;
    tgt = 1'b0; psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 8'h14; pwdata = $urandom; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    if (rdy[0] === 1'b1) hi++;
    psel = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rdy[0] === 1'b1) hi++;
    end
    penable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rdy[0] === 1'b1) hi++;
    end
    penable = 1'b0;
    runs++;
    if (hi != 0) begin
      fails++;
      $display("FAIL abort_pready got %0d high cycles want 0", hi);
    end
    runs++;
    if (regq[0] !== flat(0)) begin
      fails++;
      $display("FAIL abort_nowrite got %h want %h", regq[0], flat(0));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, rda, d; logic er, ra; int lat, at1, at2;
    for (int t = 0; t < 2; t++) begin
      d = $urandom;
      xfer(t, 1'b1, 8'h18, d, 4'hF, rd, er, lat, at1, ra, rda);
      model_wr(t, 8'h18, d, 4'hF);
      xfer(t, 1'b0, 8'h18, 32'h0, 4'h0, rd, er, lat, at2, ra, rda);
      runs++;
      if (at2 - at1 != ((t == 0) ? 4 : 2)) begin
        fails++;
        $display("FAIL b2b_spacing[%0d] got %0d want %0d",
                 t, at2 - at1, (t == 0) ? 4 : 2);
      end
      runs++;
      if (rd !== model[t][6]) begin
        fails++;
        $display("FAIL b2b_read[%0d] got %h want %h", t, rd, model[t][6]);
      end
    end
  endtask

  task automatic test_nowait();
    logic [31:0] rd, rda, d; logic er, ra; int lat, at;
    d = $urandom;
    xfer(1, 1'b1, 8'h1C, d, 4'hF, rd, er, lat, at, ra, rda);
    model_wr(1, 8'h1C, d, 4'hF);
    runs++;
    if (lat != 1 || ra !== 1'b0 || regq[1] !== flat(1)) begin
      fails++;
      $display("FAIL nowait_write got lat=%0d after=%b want 1/0", lat, ra);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, rda, d; logic er, ra, w; int lat, at, t;
    logic [7:0] a; logic [3:0] s; logic [31:0] want;
    for (int n = 0; n < 80; n++) begin
      t = int'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 255));
      else a = {1'b0, 2'b00, 3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3))};
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      want = exp_rd(t, a);
      xfer(t, w, a, d, s, rd, er, lat, at, ra, rda);
      if (w) model_wr(t, a, d, s);
      runs++;
      if (lat != ((t == 0) ? 3 : 1) || ra !== 1'b0 || rda !== 32'h0) begin
        fails++;
        $display("FAIL rand_timing[%0d] got lat=%0d after=%b/%h", t, lat, ra, rda);
      end
      runs++;
      if (er !== (SLV && a[7:2] >= 6'(NR)) || (!w && rd !== want)) begin
        fails++;
        $display("FAIL rand_resp[%0d] a=%h got rd=%h err=%b want %h",
                 t, a, rd, er, want);
      end
      runs++;
      if (regq[t] !== flat(t)) begin
        fails++;
        $display("FAIL rand_regs[%0d] got %h want %h", t, regq[t], flat(t));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    runs++;
    if (dbl !== 2'b00) begin
      fails++;
      $display("FAIL pready_double got %b want 00", dbl);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_write();
    test_partial();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    test_nowait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end

endmodule
